// File: rtl/sync_external_trigger_multi_if.sv
// sync_external_trigger_multi_if: trigger inputs, controls and pulse/missed outputs of the multi-channel trigger synchroniser
interface sync_external_trigger_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0] ext_in;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] edge_sel;
  logic [CNT_W-1:0]  holdoff;
  logic [NUM_CH-1:0] clear_missed;
  logic [NUM_CH-1:0] pulse_out;
  logic              any_pulse;
  logic [NUM_CH-1:0] missed;
  modport master (
    output ext_in, enable, edge_sel, holdoff, clear_missed,
    input  pulse_out, any_pulse, missed
  );
  modport slave (
    input  ext_in, enable, edge_sel, holdoff, clear_missed,
    output pulse_out, any_pulse, missed
  );
endinterface

// File: rtl/sync_external_trigger_multi.sv
// sync_external_trigger_multi: per-channel trigger synchroniser with edge select, one-shot pulse, hold-off lock-out and sticky missed flags
module sync_external_trigger_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 16,
  parameter int PULSE_LEN   = 2
) (
  input logic aclk,
  input logic aresetn,
  sync_external_trigger_multi_if.slave bus
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  typedef enum logic [1:0] {DISABLED, WAIT_IDLE, ARMED, HOLDOFF} state_t;
  state_t                 state_q [NUM_CH];
  state_t                 state_d [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_q  [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d  [NUM_CH];
  logic [CNT_W-1:0]       cnt_q   [NUM_CH];
  logic [CNT_W-1:0]       cnt_d   [NUM_CH];
  logic [CNT_W-1:0]       hold_q  [NUM_CH];
  logic [CNT_W-1:0]       hold_d  [NUM_CH];
  logic [PW-1:0]          pcnt_q  [NUM_CH];
  logic [PW-1:0]          pcnt_d  [NUM_CH];
  logic [NUM_CH-1:0]      p_q, p_d, s, act, fire;
  logic [NUM_CH-1:0]      pulse_q, pulse_d, missed_q, missed_d;
  logic                   any_q, any_d;
  always_comb begin
    s        = '0;
    act      = '0;
    fire     = '0;
    p_d      = '0;
    pulse_d  = '0;
    missed_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], bus.ext_in[i]};
      s[i]        = sync_q[i][SYNC_STAGES-1] ^ bus.edge_sel[i];
      p_d[i]      = s[i];
      act[i]      = s[i] & ~p_q[i];
      fire[i]     = bus.enable[i] && state_q[i] == ARMED && act[i];
      state_d[i]  = !bus.enable[i]          ? DISABLED :
                    state_q[i] == DISABLED  ? WAIT_IDLE :
                    state_q[i] == WAIT_IDLE ? (s[i] ? WAIT_IDLE : ARMED) :
                    state_q[i] == ARMED     ? (act[i] ? HOLDOFF : ARMED) :
                    (!s[i] && cnt_q[i] >= hold_q[i]) ? ARMED : HOLDOFF;
      hold_d[i]   = fire[i] ? bus.holdoff : hold_q[i];
      // Any return of the line to the active level restarts the lock-out interval.
      cnt_d[i]    = fire[i]                 ? '0 :
                    state_q[i] != HOLDOFF   ? cnt_q[i] :
                    s[i]                    ? '0 :
                    cnt_q[i] < hold_q[i]    ? cnt_q[i] + 1'b1 : cnt_q[i];
      // The pulse counter ignores enable so a started pulse always runs to length.
      pcnt_d[i]   = fire[i] ? PW'(PULSE_LEN) : pcnt_q[i] != '0 ? pcnt_q[i] - 1'b1 : pcnt_q[i];
      pulse_d[i]  = pcnt_q[i] != '0;
      missed_d[i] = (act[i] && (state_q[i] == HOLDOFF || state_q[i] == WAIT_IDLE)) |
                    (missed_q[i] & ~bus.clear_missed[i]);
    end
    any_d = |pulse_d;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= DISABLED;
        sync_q[i]  <= '0;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
        pcnt_q[i]  <= '0;
      end
      p_q      <= '0;
      pulse_q  <= '0;
      missed_q <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        sync_q[i]  <= sync_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
      p_q      <= p_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
      any_q    <= any_d;
    end
  end
  assign bus.pulse_out = pulse_q;
  assign bus.any_pulse = any_q;
  assign bus.missed    = missed_q;
endmodule
